// File: rtl/cam_capture_ctrl.sv
// Frame-capture sequencer for the OV7670 path: arms on start, aligns to a vsync frame
// boundary, gates pixel writes, counts lines/frames and flags overflow/geometry errors.
module cam_capture_ctrl #(
  parameter int AW       = 15,
  parameter int FW       = 8,
  parameter int LW       = 8,
  parameter int V_LINES  = 120,
  parameter int MAX_ADDR = 19199
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          mode_cont,
  input  logic [FW-1:0] n_frames,
  input  logic          vsync,
  input  logic          href,
  input  logic          px_wr,
  input  logic [AW-1:0] mem_px_addr,
  output logic          cap_en,
  output logic          addr_clr,
  output logic          busy,
  output logic          done,
  output logic [FW-1:0] frame_cnt,
  output logic [LW-1:0] line_cnt,
  output logic          err_ovf,
  output logic          err_geom
);

  localparam logic [AW-1:0] MAX_A = AW'(MAX_ADDR);
  localparam logic [LW-1:0] V_L   = LW'(V_LINES);

  typedef enum logic [1:0] {IDLE, ARM, SYNC, CAPTURE} state_t;

  state_t        state_q, state_d;
  logic          vs_q, hr_q;
  logic          cap_en_q, cap_en_d;
  logic          addr_clr_q, addr_clr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [LW-1:0] line_cnt_q, line_cnt_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_geom_q, err_geom_d;
  logic          stop_pend_q, stop_pend_d;
  logic [FW-1:0] n_latch_q, n_latch_d;

  logic          vs_rise, vs_fall, hr_fall;
  logic [FW-1:0] frame_inc;
  logic          last_frame;

  function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign vs_rise    = vsync & ~vs_q;
  assign vs_fall    = ~vsync & vs_q;
  assign hr_fall    = ~href & hr_q;
  assign frame_inc  = frame_cnt_q + 1'b1;
  // A stop arriving together with the frame-ending vs_rise still counts as pending.
  assign last_frame = stop_pend_q | stop | (~mode_cont & (frame_inc == n_latch_q));

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= IDLE;
      vs_q        <= 1'b0;
      hr_q        <= 1'b0;
      cap_en_q    <= 1'b0;
      addr_clr_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
      line_cnt_q  <= '0;
      err_ovf_q   <= 1'b0;
      err_geom_q  <= 1'b0;
      stop_pend_q <= 1'b0;
      n_latch_q   <= '0;
    end else begin
      state_q     <= state_d;
      vs_q        <= vsync;
      hr_q        <= href;
      cap_en_q    <= cap_en_d;
      addr_clr_q  <= addr_clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
      line_cnt_q  <= line_cnt_d;
      err_ovf_q   <= err_ovf_d;
      err_geom_q  <= err_geom_d;
      stop_pend_q <= stop_pend_d;
      n_latch_q   <= n_latch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ARM;
      ARM:     if (stop) state_d = IDLE;
               else if (vs_rise) state_d = SYNC;
      SYNC:    if (stop) state_d = IDLE;
               else if (vs_fall) state_d = CAPTURE;
      CAPTURE: if (vs_rise) state_d = last_frame ? IDLE : SYNC;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cap_en_d    = cap_en_q;
    addr_clr_d  = 1'b0;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    line_cnt_d  = line_cnt_q;
    err_ovf_d   = err_ovf_q;
    err_geom_d  = err_geom_q;
    stop_pend_d = stop_pend_q;
    n_latch_d   = n_latch_q;
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_clr_d  = 1'b1;
          frame_cnt_d = '0;
          line_cnt_d  = '0;
          err_ovf_d   = 1'b0;
          err_geom_d  = 1'b0;
          stop_pend_d = 1'b0;
          n_latch_d   = (n_frames == '0) ? FW'(1) : n_frames;
        end
      end
      SYNC: begin
        if (!stop && vs_fall) begin
          line_cnt_d = '0;
          cap_en_d   = 1'b1;
        end
      end
      CAPTURE: begin
        if (hr_fall) line_cnt_d = sat_inc(line_cnt_q);
        // Last buffer slot written: hold writes off until the next frame.
        if (px_wr && mem_px_addr == MAX_A) cap_en_d = 1'b0;
        if (px_wr && mem_px_addr > MAX_A) err_ovf_d = 1'b1;
        if (stop) stop_pend_d = 1'b1;
        if (vs_rise) begin
          cap_en_d    = 1'b0;
          frame_cnt_d = frame_inc;
          if (line_cnt_d != V_L) err_geom_d = 1'b1;
          if (last_frame) done_d = 1'b1;
          else addr_clr_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign cap_en    = cap_en_q;
  assign addr_clr  = addr_clr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;
  assign line_cnt  = line_cnt_q;
  assign err_ovf   = err_ovf_q;
  assign err_geom  = err_geom_q;

endmodule
